// File: rtl/cpu_pkg.sv
// Shared CPU definitions: arbiter state encoding and requester indices.
// Optional round-robin arbitration is selected with MEM_ARB_ROUND_ROBIN_EN.
package cpu_pkg;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] ACCESS = 2'b01;
   localparam logic [1:0] RESP   = 2'b10;

   localparam int REQ_FETCH = 0;
   localparam int REQ_DATA  = 1;
   localparam int REQ_DBG   = 2;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select for mem_port_arbiter: lock override, then
// fixed priority or, with MEM_ARB_ROUND_ROBIN_EN, round-robin from start_ptr.
module arb_pick #(
   parameter int NREQ = 3,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic [IW-1:0]   start_ptr,
`endif
   input  logic            lock_held,
   input  logic [IW-1:0]   last_owner,
   output logic [NREQ-1:0] winner,
   output logic [IW-1:0]   win_idx,
   output logic            any
);

   int unsigned     cand;
   logic [IW-1:0]   ci;

   always_comb begin
      any     = 1'b0;
      win_idx = '0;
      cand    = 0;
      ci      = '0;
      if (lock_held && req[last_owner]) begin
         any     = 1'b1;
         win_idx = last_owner;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            cand = (32'(start_ptr) + i) % NREQ;
`else
            cand = i;
`endif
            ci = IW'(cand);
            if (!any && req[ci]) begin
               any     = 1'b1;
               win_idx = ci;
            end
         end
      end
      winner = any ? (NREQ'(1) << win_idx) : '0;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: capture / drive memory / return data, one access
// per three cycles. MEM_ARB_ROUND_ROBIN_EN enables round-robin selection.
module mem_port_arbiter
   import cpu_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int AW   = 8,
   parameter int DW   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  lock,
   input  logic [NREQ-1:0]  we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]  gnt,
   output logic [NREQ-1:0]  done,
   output logic [DW-1:0]    rdata,
   output logic             busy,
   output logic             mem_en,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   input  logic [DW-1:0]    mem_rdata
);

   localparam int IW = $clog2(NREQ);

   logic [1:0]      state;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   last_owner;
   logic            lock_held;
   logic            cap_we;
   logic [AW-1:0]   cap_addr;
   logic [DW-1:0]   cap_wdata;

   logic [NREQ-1:0] pick_onehot;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic [IW-1:0]   rr_ptr;
`endif

   arb_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req        (req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .start_ptr  (rr_ptr),
`endif
      .lock_held  (lock_held),
      .last_owner (last_owner),
      .winner     (pick_onehot),
      .win_idx    (pick_idx),
      .any        (pick_any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         gnt        <= '0;
         done       <= '0;
         rdata      <= '0;
         owner      <= '0;
         last_owner <= IW'(REQ_FETCH);
         lock_held  <= 1'b0;
         cap_we     <= 1'b0;
         cap_addr   <= '0;
         cap_wdata  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         rr_ptr     <= '0;
`endif
      end else begin
         gnt  <= '0;
         done <= '0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  owner     <= pick_idx;
                  cap_we    <= we[pick_idx];
                  cap_addr  <= addr[pick_idx*AW +: AW];
                  cap_wdata <= wdata[pick_idx*DW +: DW];
                  gnt       <= pick_onehot;
                  state     <= ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  if (int'(pick_idx) == NREQ - 1) rr_ptr <= '0;
                  else                            rr_ptr <= pick_idx + 1'b1;
`endif
               end
            end
            ACCESS: state <= RESP;
            RESP: begin
               if (!cap_we) rdata <= mem_rdata;
               done       <= NREQ'(1) << owner;
               last_owner <= owner;
               lock_held  <= lock[owner];
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory strobes decode from state so requesters never reach the macro combinationally.
   always_comb begin
      busy      = (state != IDLE);
      mem_en    = (state == ACCESS);
      mem_we    = (state == ACCESS) && cap_we;
      mem_addr  = cap_addr;
      mem_wdata = cap_wdata;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural memory.
// Contention expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 8;
   localparam int DW   = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req, lock, we;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]    gnt, done;
   logic [DW-1:0]      rdata;
   logic               busy, mem_en, mem_we;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata;
   logic [DW-1:0]      mem_rdata;

   logic [DW-1:0]      mem [256];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .NREQ (NREQ),
      .AW   (AW),
      .DW   (DW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .lock      (lock),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .done      (done),
      .rdata     (rdata),
      .busy      (busy),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Synchronous single-port memory macro: read data one cycle after mem_en.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      lock  = '0;
      we    = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_port(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      we[k]             = w;
      addr[k*AW +: AW]  = a;
      wdata[k*DW +: DW] = d;
   endtask

   logic [NREQ-1:0] exp_g [4];

   initial begin
      addr  = '0;
      wdata = '0;
      mem_rdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 8'hA5;
      mem[8'h40] = 8'h5A;

      do_reset();
      check_eq("rst_gnt",   32'(gnt), 0);
      check_eq("rst_done",  32'(done), 0);
      check_eq("rst_rdata", 32'(rdata), 0);
      check_eq("rst_busy",  32'(busy), 0);
      check_eq("rst_mem",   32'({mem_en, mem_we, mem_addr, mem_wdata}), 0);

      // Single read from requester 0
      set_port(0, 1'b0, 8'h10, 8'h00);
      req = 3'b001;
      tick();
      check_eq("rd_gnt",   32'(gnt), 32'b001);
      check_eq("rd_mem_en", 32'(mem_en), 1);
      check_eq("rd_mem_we", 32'(mem_we), 0);
      check_eq("rd_addr",  32'(mem_addr), 32'h10);
      check_eq("rd_busy",  32'(busy), 1);
      req = '0;
      tick();
      check_eq("rd_resp_gnt",  32'(gnt), 0);
      check_eq("rd_resp_en",   32'(mem_en), 0);
      check_eq("rd_resp_done", 32'(done), 0);
      tick();
      check_eq("rd_done",  32'(done), 32'b001);
      check_eq("rd_rdata", 32'(rdata), 32'hA5);
      check_eq("rd_idle",  32'(busy), 0);
      tick();
      check_eq("rd_done_pulse", 32'(done), 0);

      // Write 3C to 20 from requester 1, then read it back
      set_port(1, 1'b1, 8'h20, 8'h3C);
      req = 3'b010;
      tick();
      check_eq("wr_gnt",   32'(gnt), 32'b010);
      check_eq("wr_mem_we", 32'(mem_we), 1);
      check_eq("wr_addr",  32'(mem_addr), 32'h20);
      check_eq("wr_wdata", 32'(mem_wdata), 32'h3C);
      req = '0;
      tick();
      tick();
      check_eq("wr_done",  32'(done), 32'b010);
      check_eq("wr_rdata_kept", 32'(rdata), 32'hA5);
      set_port(1, 1'b0, 8'h20, 8'h00);
      req = 3'b010;
      tick();
      check_eq("rb_gnt", 32'(gnt), 32'b010);
      req = '0;
      tick();
      tick();
      check_eq("rb_done",  32'(done), 32'b010);
      check_eq("rb_rdata", 32'(rdata), 32'h3C);

      // Contention with all requesters held high
      do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
`else
      exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001; exp_g[3] = 3'b001;
`endif
      set_port(0, 1'b0, 8'h10, 8'h00);
      set_port(1, 1'b0, 8'h20, 8'h00);
      set_port(2, 1'b0, 8'h40, 8'h00);
      req = 3'b111;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq($sformatf("cont_gnt%0d", i), 32'(gnt), 32'(exp_g[i]));
         tick();
         check_eq($sformatf("cont_gap%0d", i), 32'(gnt), 0);
         tick();
         check_eq($sformatf("cont_done%0d", i), 32'(done), 32'(exp_g[i]));
      end
      req = '0;
      tick();
      tick();
      tick();

      // Lock: requester 2 keeps priority while lock[2] is set
      do_reset();
      req  = 3'b100;
      lock = 3'b100;
      tick();
      check_eq("lk_gnt0", 32'(gnt), 32'b100);
      req = 3'b101;
      tick();
      tick();
      check_eq("lk_done0", 32'(done), 32'b100);
      tick();
      check_eq("lk_gnt1", 32'(gnt), 32'b100);
      lock = 3'b000;
      tick();
      tick();
      check_eq("lk_done1", 32'(done), 32'b100);
      tick();
      check_eq("unlk_gnt", 32'(gnt), 32'b001);
      req = '0;
      tick();
      tick();
      check_eq("unlk_done", 32'(done), 32'b001);

      // Reset asserted during ACCESS abandons the access
      tick();
      req = 3'b001;
      tick();
      check_eq("rm_en", 32'(mem_en), 1);
      reset = 1'b1;
      req   = '0;
      tick();
      reset = 1'b0;
      check_eq("rm_busy", 32'(busy), 0);
      check_eq("rm_en_off", 32'(mem_en), 0);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("rm_nodone%0d", i), 32'(done), 0);
         tick();
      end

      // Idle: nothing moves without requests
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq($sformatf("idle%0d", i), 32'({mem_en, gnt, done, busy}), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single-port instruction/data memory among NREQ requesters (index 0 = instruction fetch, 1 = accumulator load/store, 2 = debug/loader port). Sequences each access through a fixed three-state cycle (capture, drive memory, return data) and reports completion per requester with a one-hot pulse. It sits between the controller's fetch/load-store request logic and the memory macro.

## Interface
- NREQ, 3, number of requesters (2..8)
- AW, 8, memory address width
- DW, 8, memory data width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req  in  NREQ  per-requester access request, level
- lock  in  NREQ  owner keeps priority for its next request
- we  in  NREQ  1 = write, 0 = read
- addr  in  NREQ*AW  packed addresses, slice k = addr[k*AW +: AW]
- wdata  in  NREQ*DW  packed write data, same slicing
- gnt  out  NREQ  one-hot, request accepted
- done  out  NREQ  one-hot, access complete; rdata valid if read
- rdata  out  DW  read data, held until next read completes
- busy  out  1  state != IDLE
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en

## Operation
- States: IDLE, ACCESS, RESP. Reset/default state IDLE.
- IDLE: if any req bit set, select winner w, capture we[w]/addr[w]/wdata[w] and owner <= w, set gnt <= onehot(w), go ACCESS; otherwise stay in IDLE.
- ACCESS: mem_en=1, mem_we/mem_addr/mem_wdata driven from captured registers; all req inputs ignored; go RESP.
- RESP: if captured op is a read, rdata <= mem_rdata; done <= onehot(owner); last_owner <= owner; lock_held <= lock[owner]; go IDLE.
- Selection: if lock_held and req[last_owner], last_owner wins. Otherwise fixed priority, lowest index wins.
- gnt and done are single-cycle pulses; never more than one bit set.
- A requester may drop req the cycle after gnt; if req is still high in the done cycle, it is re-arbitrated as a new request.
- Requester inputs need to be stable only in the IDLE cycle in which they are sampled.
- Write: rdata unchanged; done still pulses.
- Reset at any point: state IDLE, in-flight access abandoned, no done issued, lock_held=0, last_owner=0.
- Reset values: gnt=0, done=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

## Timing
- Request sampled at end of cycle N (IDLE) -> gnt and mem_en high in cycle N+1 -> memory data in cycle N+2 (RESP) -> done and rdata in cycle N+3.
- Cycle N+3 is IDLE, so a new request can be sampled the same cycle. Peak throughput is one access per 3 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from req to any output.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: non-locked selection is round-robin. Pointer rr_ptr resets to 0; the search starts at rr_ptr upward and wraps modulo NREQ. After each grant to w, rr_ptr <= (w+1) mod NREQ. Lock override still applies.
- Undefined: fixed priority, index 0 highest; rr_ptr is not implemented.

## Structure
- Shared package cpu_pkg holds:
  - state encoding: IDLE=2'b00, ACCESS=2'b01, RESP=2'b10
  - requester index constants: REQ_FETCH=0, REQ_DATA=1, REQ_DBG=2
- One sub-module, arb_pick: combinational winner select. Inputs req, start pointer, lock_held, last_owner; outputs one-hot winner plus index. Both priority modes live here under the macro.

## Test plan
- Single read: req[0]=1, addr0=8'h10, memory holds 8'hA5 -> gnt=3'b001 in cycle 1, mem_en cycle 1 with mem_addr=8'h10, done=3'b001 and rdata=8'hA5 in cycle 3.
- Write then read: req[1] write 8'h3C to 8'h20, then read 8'h20 -> second done returns rdata=8'h3C; rdata unchanged after the write's done.
- Contention: req=3'b111 held continuously -> fixed priority grants 0,0,0...; with MEM_ARB_ROUND_ROBIN_EN grants 0,1,2,0 with 3-cycle spacing.
- Lock: requester 2 wins with lock[2]=1 and re-requests while req[0]=1 -> next grant 3'b100; with lock[2]=0 the next grant is 3'b001.
- Reset mid-op: assert reset in the ACCESS cycle -> next cycle busy=0, mem_en=0, no done pulse ever issued for that access.
- Idle: req=0 for 10 cycles -> mem_en, gnt and done stay 0; busy=0.
